muxn_reg: RTL

MUXN_REG -- requirements
Module: muxn_reg

---
 rtl/muxn_reg.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/muxn_reg.sv
// muxn_reg: N-channel valid/ready multiplexer into a single-entry output register.
// Latency: 1 cycle from accepted input to out_valid; back-to-back words flow with no bubble.
// Backpressure: while out_valid && !out_ready the word holds and every in_ready bit is 0.
//
// Ports:
//   clk, rst_n        - clock (rising edge) and asynchronous active-low reset
//   in_data/in_valid  - N channels, channel i at in_data[i*WIDTH +: WIDTH]
//   in_ready          - one-hot (or zero) accept strobe toward the granted channel
//   sel, mode         - explicit channel select (mode=0) or round-robin (mode=1)
//   out_data/out_chan - registered word and the index of the channel it came from
//   out_valid/ready   - output handshake
//
// Build option: define MUXN_REG_RR_EN to enable round-robin arbitration.
// Without it the mode port is ignored, the block always uses sel, and no
// round-robin pointer exists.
module muxn_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;

  logic             can_accept;
  logic             sel_vld;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // Output register can take a new word when empty or being drained this cycle.
  assign can_accept = !out_valid_q || out_ready;

  // Explicit select: compare against each legal index so that sel >= N
  // simply never matches and produces no grant.
  always_comb begin
    sel_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i) && in_valid[i]) sel_vld = 1'b1;
    end
  end

`ifdef MUXN_REG_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            rr_vld;
  logic [SELW-1:0] rr_idx;

  // Scan distances from farthest to nearest so the valid channel closest to
  // ptr (in wrap-around order) is the last, and therefore winning, assignment.
  // ptr + k < 2N, so the wrap is a single subtraction of N.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + N))) begin
          rr_vld = 1'b1;
          rr_idx = SELW'(i);
        end
      end
    end
  end

  assign grant_vld = mode ? rr_vld : sel_vld;
  assign grant_idx = mode ? rr_idx : sel;

  // Pointer advances past the winner only on a round-robin transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && mode) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign grant_vld   = sel_vld;
  assign grant_idx   = sel;
`endif

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // rst_n gates the strobe directly: during reset the register reads empty,
  // which would otherwise look like free space.
  assign xfer = rst_n && grant_vld && can_accept;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (grant_idx == SELW'(i));
    end
  end

  // Load wins over pop, which gives bubble-free replacement on a
  // simultaneous drain and fill.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
